// File: rtl/alu_seq_pkg.sv
// Shared types for the relay ALU sequencer: op codes, FSM states, settle bounds.
// Pure declarations; no logic, latency or backpressure of its own.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_INC = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_NOT = 3'd5,
    OP_SHL = 3'd6,
    OP_CLR = 3'd7
  } alu_op_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SELECT = 3'd1,
    S_SETTLE = 3'd2,
    S_LATCH  = 3'd3,
    S_DONE   = 3'd4
  } seq_state_t;

  localparam int SETTLE_MAX = 15;
  localparam int SETTLE_W   = 4;

  // SHL reports the bit shifted out of bit 7 on the adder carry line.
  function automatic logic op_sets_carry(alu_op_t o);
    return (o == OP_ADD) || (o == OP_INC) || (o == OP_SHL);
  endfunction

endpackage

// File: rtl/settle_timer.sv
// Relay-settle down-counter: load has priority over decrement, zero is combinational.
// Latency 1 cycle from load/dec to count; no backpressure.
module settle_timer
  import alu_seq_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [SETTLE_W-1:0] load_val,
  input  logic                dec,
  output logic                zero
);

  logic [SETTLE_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (dec && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/alu_sequencer.sv
// Sequences one ALU op: select, hold SETTLE_CYCLES, strobe A/D, done; start-to-done = SETTLE_CYCLES+3.
// start ignored while busy (no queueing); flag registers exist only with ALU_SEQ_COND_EN defined.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic             dest_d,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry_out,
  output logic             busy,
  output logic             done,
  output logic [2:0]       alu_fn,
  output logic             alu_oe,
  output logic             load_a,
  output logic             load_d,
  output logic [WIDTH-1:0] result,
  output logic             flag_sign,
  output logic             flag_carry,
  output logic             flag_zero
);

  seq_state_t state_q, state_d;
  alu_op_t    op_q;
  logic       dest_q;
  logic       settle_zero;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_SELECT;
      S_SELECT: state_d = S_SETTLE;
      S_SETTLE: if (settle_zero) state_d = S_LATCH;
      S_LATCH:  state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy   = 1'b1;
    done   = 1'b0;
    alu_oe = 1'b0;
    alu_fn = 3'd0;
    load_a = 1'b0;
    load_d = 1'b0;
    case (state_q)
      S_IDLE: busy = 1'b0;
      S_SELECT, S_SETTLE: begin
        alu_oe = 1'b1;
        alu_fn = op_q;
      end
      S_LATCH: begin
        alu_oe = 1'b1;
        alu_fn = op_q;
        load_a = ~dest_q;
        load_d = dest_q;
      end
      S_DONE: begin
        done   = 1'b1;
        alu_fn = op_q;
      end
      default: busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q   <= OP_ADD;
      dest_q <= 1'b0;
    end else if ((state_q == S_IDLE) && start) begin
      op_q   <= alu_op_t'(op);
      dest_q <= dest_d;
    end
  end

  // Counter reaches SETTLE_CYCLES-1 at the end of SELECT, so SETTLE lasts SETTLE_CYCLES cycles.
  settle_timer u_settle_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (state_q == S_SELECT),
    .load_val (SETTLE_W'(SETTLE_CYCLES - 1)),
    .dec      (state_q == S_SETTLE),
    .zero     (settle_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      result <= '0;
    end else if (state_q == S_LATCH) begin
      result <= alu_result;
    end
  end

`ifdef ALU_SEQ_COND_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      flag_sign  <= 1'b0;
      flag_carry <= 1'b0;
      flag_zero  <= 1'b0;
    end else if (state_q == S_LATCH) begin
      flag_sign  <= alu_result[WIDTH-1];
      flag_carry <= op_sets_carry(op_q) ? alu_carry_out : 1'b0;
      flag_zero  <= (alu_result == '0);
    end
  end
`else
  logic unused_carry;
  assign unused_carry = alu_carry_out;
  assign flag_sign    = 1'b0;
  assign flag_carry   = 1'b0;
  assign flag_zero    = 1'b0;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: timing, strobes, flags, mid-op reset, back-to-back ops.
// Expected flags follow ALU_SEQ_COND_EN so the same bench serves both builds.
module tb_alu_sequencer;

  localparam int W = 8;
  localparam int S = 3;

  logic         clk = 1'b0;
  logic         reset, start, dest_d, alu_carry_out;
  logic [2:0]   op;
  logic [W-1:0] alu_result;
  logic         busy, done, alu_oe, load_a, load_d;
  logic [2:0]   alu_fn;
  logic [W-1:0] result;
  logic         flag_sign, flag_carry, flag_zero;

  int n_vec = 0;
  int n_err = 0;

  logic [W-1:0] exp_result = '0;
  logic         exp_s = 1'b0, exp_c = 1'b0, exp_z = 1'b0;

  always #5 clk = ~clk;

  alu_sequencer #(.WIDTH(W), .SETTLE_CYCLES(S)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .op            (op),
    .dest_d        (dest_d),
    .alu_result    (alu_result),
    .alu_carry_out (alu_carry_out),
    .busy          (busy),
    .done          (done),
    .alu_fn        (alu_fn),
    .alu_oe        (alu_oe),
    .load_a        (load_a),
    .load_d        (load_d),
    .result        (result),
    .flag_sign     (flag_sign),
    .flag_carry    (flag_carry),
    .flag_zero     (flag_zero)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"},  busy,   0);
    chk({tag, "_done"},  done,   0);
    chk({tag, "_oe"},    alu_oe, 0);
    chk({tag, "_fn"},    alu_fn, 0);
    chk({tag, "_loada"}, load_a, 0);
    chk({tag, "_loadd"}, load_d, 0);
  endtask

  // One operation starting at the next negedge; poke = cycle index at which start is re-pulsed (0 = never).
  task automatic run_op(input logic [2:0] o, input logic d, input logic [W-1:0] res,
                        input logic co, input int poke);
    int load_n, done_n, nload;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_fn", alu_fn, 0);
    chk("hold_result", result, exp_result);
    chk("hold_flags", {flag_sign, flag_carry, flag_zero}, {exp_s, exp_c, exp_z});
    op = o; dest_d = d; alu_result = res; alu_carry_out = co; start = 1'b1;
`ifdef ALU_SEQ_COND_EN
    exp_s = res[W-1];
    exp_z = (res == '0);
    exp_c = (o == 3'd0 || o == 3'd1 || o == 3'd6) ? co : 1'b0;
`else
    exp_s = 1'b0; exp_z = 1'b0; exp_c = 1'b0;
`endif
    exp_result = res;
    load_n = 0; done_n = 0; nload = 0;
    for (int n = 1; n <= 20 && done_n == 0; n++) begin
      @(negedge clk);
      start = (n == poke);
      if (n == 1) begin
        chk("sel_busy", busy, 1);
        chk("sel_oe", alu_oe, 1);
        chk("sel_fn", alu_fn, o);
      end
      if (load_a || load_d) begin
        nload++;
        if (load_n == 0) load_n = n;
        chk("load_a_sel", load_a, !d);
        chk("load_d_sel", load_d, d);
      end
      if (done) begin
        done_n = n;
        chk("done_oe", alu_oe, 0);
        chk("done_busy", busy, 1);
        chk("result", result, res);
        chk("flag_sign", flag_sign, exp_s);
        chk("flag_carry", flag_carry, exp_c);
        chk("flag_zero", flag_zero, exp_z);
      end
    end
    start = 1'b0;
    chk("load_latency", load_n, S + 2);
    chk("done_latency", done_n, S + 3);
    chk("load_count", nload, 1);
  endtask

  initial begin
    int nload;
    reset = 1'b1; start = 1'b0; op = 3'd0; dest_d = 1'b0;
    alu_result = '0; alu_carry_out = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle_outputs("rst");
    chk("rst_result", result, 0);
    chk("rst_flags", {flag_sign, flag_carry, flag_zero}, 0);
    reset = 1'b0;

    run_op(3'd0, 1'b0, 8'h80, 1'b0, 0);  // ADD -> A, negative
    run_op(3'd0, 1'b1, 8'h00, 1'b1, 0);  // ADD -> D, zero with carry, back-to-back
    run_op(3'd2, 1'b0, 8'hF0, 1'b1, 3);  // AND ignores carry; start poked in SETTLE
    run_op(3'd6, 1'b1, 8'h02, 1'b1, 0);  // SHL carries shifted-out bit
    run_op(3'd4, 1'b0, 8'h5A, 1'b1, 0);  // XOR clears carry

    // Reset during SETTLE aborts without a write.
    @(negedge clk);
    op = 3'd1; dest_d = 1'b0; alu_result = 8'h7F; alu_carry_out = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_abort_busy", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    chk_idle_outputs("abort");
    chk("abort_result", result, 0);
    chk("abort_flags", {flag_sign, flag_carry, flag_zero}, 0);
    reset = 1'b0;
    exp_result = '0; exp_s = 1'b0; exp_c = 1'b0; exp_z = 1'b0;
    nload = 0;
    repeat (6) begin
      @(negedge clk);
      if (load_a || load_d || done) nload++;
    end
    chk("abort_no_write", nload, 0);

    run_op(3'd1, 1'b0, 8'h01, 1'b1, 0);  // INC accepted after abort

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Sequences one 8-bit ALU operation on the relay-computer datapath: drives the ALU function select and B/C operand enables, waits a programmable relay-settle interval, then strobes the result into destination register A or D and latches condition flags. Sits between the instruction decoder and the ALU, which is an 8-stage ripple adder made of adder blocks plus logic units. Models relay settle time as clock cycles so the synthesizable core matches the original machine's timing.

Parameters:
WIDTH, 8, datapath width in bits
SETTLE_CYCLES, 3, cycles the ALU inputs are held before the result is sampled (min 1, max 15)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  request one ALU operation; sampled only in IDLE
op  input  3  0 ADD, 1 INC, 2 AND, 3 OR, 4 XOR, 5 NOT, 6 SHL, 7 CLR
dest_d  input  1  0 = write result to A, 1 = write result to D
alu_result  input  WIDTH  combinational ALU output
alu_carry_out  input  1  carry out of adder bit 7
busy  output  1  operation in progress
done  output  1  one-cycle pulse, result written
alu_fn  output  3  function select to ALU
alu_oe  output  1  gates B/C onto ALU inputs
load_a  output  1  one-cycle load strobe to register A
load_d  output  1  one-cycle load strobe to register D
result  output  WIDTH  registered copy of latched result
flag_sign  output  1  result[WIDTH-1]
flag_carry  output  1  carry flag
flag_zero  output  1  result == 0

Behaviour:
- Reset: state IDLE; busy, done, alu_oe, load_a, load_d = 0; alu_fn = 0; result = 0; all flags = 0. Reset mid-operation aborts with no load strobe; no partial write.
- States: IDLE -> SELECT -> SETTLE -> LATCH -> DONE -> IDLE.
- IDLE: start=1 at cycle T captures op and dest_d into internal registers; next state SELECT. start in any other state is ignored. There is no queueing.
- SELECT (T+1): alu_fn = captured op, alu_oe = 1, busy = 1; settle counter loaded with SETTLE_CYCLES-1.
- SETTLE (T+2 .. T+1+SETTLE_CYCLES): alu_oe and alu_fn held; counter decrements and exits at 0.
- LATCH (T+2+SETTLE_CYCLES): result <= alu_result. Exactly one of load_a/load_d is asserted per captured dest_d. Flags update.
- DONE (T+3+SETTLE_CYCLES): done = 1, alu_oe = 0, busy = 1; then IDLE. Start-to-done latency = SETTLE_CYCLES+3. Back-to-back start accepted the cycle after DONE.
- busy = 1 in every state except IDLE. alu_fn returns to 0 in IDLE.
- Flag rules:
  - carry = alu_carry_out for ADD and INC.
  - carry = alu_result-independent bit shifted out for SHL, taken from alu_carry_out.
  - carry = 0 for all other ops.
  - sign/zero follow the latched result.
- Flags and result hold their values between operations.

Optional Feature:
Macro ALU_SEQ_COND_EN.
- Defined: flags behave as above.
- Undefined: flag registers are removed and flag_sign, flag_carry, flag_zero are tied to 0. All other timing is unchanged.

Decomposition:
- Package alu_seq_pkg holds:
  - enum alu_op_t (the 8 op codes above);
  - enum seq_state_t;
  - constant SETTLE_MAX = 15.
- One natural sub-module, settle_timer: a down-counter with load, a zero flag and a 4-bit width.

Test Plan:
- Reset, then ADD, SETTLE_CYCLES=3, alu_result=0x80, alu_carry_out=0, dest_d=0, start at T -> load_a pulse at T+5, done at T+6, result 0x80, sign=1, zero=0, carry=0.
- ADD with alu_result=0x00, alu_carry_out=1, dest_d=1 -> load_d only, zero=1, carry=1, sign=0.
- AND with alu_carry_out=1 -> carry=0. start pulsed during SETTLE -> ignored, exactly one done.
- Reset asserted during SETTLE -> no load_a/load_d, all outputs 0 next cycle, new start accepted.
- Two back-to-back ops (start in the cycle after done) -> second done at 6 cycles after its start, with no gap violation.
- Build without ALU_SEQ_COND_EN, run ADD producing 0x00 with carry -> all flags stay 0 and result = 0x00.
